mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 7 +
 rtl/mem_tag_owner_table.sv | 31 +++
 rtl/mem_bus_arbiter.sv | 74 +++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared bus command and tag owner encodings for the memory controller
package mem_bus_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int TAG_W = 4;
  typedef enum logic [1:0] {BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2} bus_command_t;
  typedef enum logic [1:0] {OWNER_NONE = 2'd0, OWNER_ICACHE = 2'd1, OWNER_DCACHE = 2'd2} mem_owner_t;
endpackage

// File: rtl/mem_tag_owner_table.sv
// mem_tag_owner_table: tags 1..15 -> owner; write port records, clear port reads and releases, count of owned tags
module mem_tag_owner_table
  import mem_bus_arbiter_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             write_en,
  input  logic [TAG_W-1:0] write_tag,
  input  mem_owner_t       write_owner,
  output mem_owner_t       write_prior,
  input  logic             clear_en,
  input  logic [TAG_W-1:0] clear_tag,
  output mem_owner_t       clear_owner,
  output logic [4:0]       count
);
  mem_owner_t owner [16];
  assign write_prior = write_tag == '0 ? OWNER_NONE : owner[write_tag];
  assign clear_owner = clear_tag == '0 ? OWNER_NONE : owner[clear_tag];
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) owner[i] <= OWNER_NONE;
    end else begin
      if (clear_en) owner[clear_tag] <= OWNER_NONE;
      if (write_en) owner[write_tag] <= write_owner;
    end
  end
  always_comb begin
    count = '0;
    for (int i = 1; i < 16; i++) count = count + 5'(owner[i] != OWNER_NONE);
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: icache/dcache arbitration onto one memory port with tag-based return routing
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       icache2ctlr_command,
  input  logic [XLEN-1:0]  icache2ctlr_addr,
  input  logic [1:0]       dcache2ctlr_command,
  input  logic [XLEN-1:0]  dcache2ctlr_addr,
  input  logic [63:0]      dcache2ctlr_data,
  input  logic [TAG_W-1:0] mem2ctlr_response,
  input  logic [63:0]      mem2ctlr_data,
  input  logic [TAG_W-1:0] mem2ctlr_tag,
  output logic [1:0]       ctlr2mem_command,
  output logic [XLEN-1:0]  ctlr2mem_addr,
  output logic [63:0]      ctlr2mem_data,
  output logic [TAG_W-1:0] Ctlr2icache_response,
  output logic [63:0]      Ctlr2icache_data,
  output logic [TAG_W-1:0] Ctlr2icache_tag,
  output logic [TAG_W-1:0] Ctlr2proc_response,
  output logic [63:0]      Ctlr2proc_data,
  output logic [TAG_W-1:0] Ctlr2proc_tag,
  output logic [4:0]       outstanding_cnt,
  output logic             tag_conflict
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;
  logic icache_req, dcache_req, grant_i, grant_d, accept, done, drop, overwrite;
  mem_owner_t write_prior, clear_owner;
  assign icache_req = icache2ctlr_command != BUS_NONE;
  assign dcache_req = dcache2ctlr_command != BUS_NONE;
  // dcache wins ties until icache has been refused STARVE_LIMIT cycles in a row
  assign grant_i = icache_req && (!dcache_req || starve_cnt == SW'(STARVE_LIMIT));
  assign grant_d = dcache_req && !grant_i;
  assign ctlr2mem_command = grant_i ? icache2ctlr_command : grant_d ? dcache2ctlr_command : BUS_NONE;
  assign ctlr2mem_addr = grant_i ? icache2ctlr_addr : grant_d ? dcache2ctlr_addr : '0;
  assign ctlr2mem_data = grant_d ? dcache2ctlr_data : '0;
  assign Ctlr2icache_response = grant_i ? mem2ctlr_response : '0;
  assign Ctlr2proc_response = grant_d ? mem2ctlr_response : '0;
  assign accept = (grant_i || grant_d) && mem2ctlr_response != '0;
  assign done = mem2ctlr_tag != '0 && clear_owner != OWNER_NONE;
  assign drop = mem2ctlr_tag != '0 && clear_owner == OWNER_NONE;
  // a tag completing in the same cycle it is reissued is a legal reuse, not a conflict
  assign overwrite = accept && write_prior != OWNER_NONE && !(done && mem2ctlr_tag == mem2ctlr_response);
  assign Ctlr2icache_tag = done && clear_owner == OWNER_ICACHE ? mem2ctlr_tag : '0;
  assign Ctlr2icache_data = done && clear_owner == OWNER_ICACHE ? mem2ctlr_data : '0;
  assign Ctlr2proc_tag = done && clear_owner == OWNER_DCACHE ? mem2ctlr_tag : '0;
  assign Ctlr2proc_data = done && clear_owner == OWNER_DCACHE ? mem2ctlr_data : '0;
  mem_tag_owner_table u_table (
    .clock(clock),
    .reset(reset),
    .write_en(accept && !reset),
    .write_tag(mem2ctlr_response),
    .write_owner(grant_i ? OWNER_ICACHE : OWNER_DCACHE),
    .write_prior(write_prior),
    .clear_en(done && !reset),
    .clear_tag(mem2ctlr_tag),
    .clear_owner(clear_owner),
    .count(outstanding_cnt)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
      tag_conflict <= 1'b0;
    end else begin
      starve_cnt <= icache_req && !(grant_i && accept)
        ? (starve_cnt == SW'(STARVE_LIMIT) ? starve_cnt : starve_cnt + 1'b1) : '0;
      if (drop || overwrite) tag_conflict <= 1'b1;
    end
  end
endmodule
